// File: rtl/membus_pkg.sv
// Shared types and constants for the MemBus arbiter and its helpers.
package membus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arbStateT;

   localparam logic M_CPU = 1'b0;
   localparam logic M_AUX = 1'b1;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/membus_arbiter_if.sv
// Bundle of both master request ports plus the shared slave-side MemBus.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface membus_arbiter_if
   import membus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_rdata;

   logic [ADDR_W-1:0] MemBus_Address;
   logic [DATA_W-1:0] MemBus_Write_Data;
   logic              MemRead;
   logic              MemWrite;
   logic [DATA_W-1:0] Device_Read_Data;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_ack, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_ack, m1_rdata,
      output MemBus_Address, MemBus_Write_Data, MemRead, MemWrite,
      input  Device_Read_Data
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_ack, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_ack, m1_rdata,
      input  MemBus_Address, MemBus_Write_Data, MemRead, MemWrite,
      output Device_Read_Data
   );

endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin chooser: on contention the master that
// did not win last time is picked.
module rr_pick2
   import membus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       lastGrant,
   output logic       grantValid,
   output logic       grantId
);

   always_comb begin
      grantValid = |req;
      if (req == 2'b11) begin
         grantId = ~lastGrant;
      end else begin
         grantId = req[M_AUX] ? M_AUX : M_CPU;
      end
   end

endmodule

// File: rtl/membus_arbiter.sv
// Two-master round-robin arbiter serialising single-word transactions onto
// the shared MemBus; each transaction runs IDLE -> ISSUE -> [WAIT] -> DONE.
module membus_arbiter
   import membus_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int READ_LATENCY = 1
) (
   input logic             clk,
   input logic             reset,
   membus_arbiter_if.slave bus
);

   generate
      if (READ_LATENCY < 0 || READ_LATENCY > 7) begin : gBadLatency
         $error("membus_arbiter: READ_LATENCY must be within 0..7");
      end
   endgenerate

   localparam logic [2:0] LAT = 3'(READ_LATENCY);

   arbStateT          state;
   arbStateT          nextState;
   logic              lastGrant;
   logic              owner;
   logic [ADDR_W-1:0] latAddr;
   logic [DATA_W-1:0] latWdata;
   logic              latWe;
   logic [DATA_W-1:0] rdCap;
   logic [2:0]        waitCnt;
   logic              grantValid;
   logic              grantId;
   logic              capture;

   rr_pick2 uPick (
      .req        ({bus.m1_req, bus.m0_req}),
      .lastGrant  (lastGrant),
      .grantValid (grantValid),
      .grantId    (grantId)
   );

   // Read data is sampled on the edge that ends ISSUE (zero latency) or the last WAIT cycle.
   assign capture = ((state == ISSUE) && !latWe && (LAT == 3'd0)) ||
                    ((state == WAIT) && (waitCnt == 3'd1));

   // NOTE: state and datapath registers use non-blocking assignments so every
   // register samples the pre-edge values; reset clears the datapath as well so
   // an aborted transaction leaves nothing stale behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lastGrant <= M_AUX;
         owner     <= M_CPU;
         latAddr   <= '0;
         latWdata  <= '0;
         latWe     <= 1'b0;
         rdCap     <= '0;
         waitCnt   <= 3'd0;
      end else begin
         state <= nextState;
         if (state == IDLE && grantValid) begin
            lastGrant <= grantId;
            owner     <= grantId;
            latAddr   <= grantId ? bus.m1_addr  : bus.m0_addr;
            latWdata  <= grantId ? bus.m1_wdata : bus.m0_wdata;
            latWe     <= grantId ? bus.m1_we    : bus.m0_we;
            rdCap     <= '0;
         end
         if (state == ISSUE) begin
            waitCnt <= LAT;
         end else if (state == WAIT) begin
            waitCnt <= waitCnt - 3'd1;
         end
         if (capture) begin
            rdCap <= bus.Device_Read_Data;
         end
      end
   end

   // NOTE: every output and nextState gets a default before the case so no
   // path through this block can infer a latch.
   always_comb begin
      nextState             = state;
      bus.MemBus_Address    = '0;
      bus.MemBus_Write_Data = '0;
      bus.MemRead           = 1'b0;
      bus.MemWrite          = 1'b0;
      bus.m0_ack            = 1'b0;
      bus.m0_rdata          = '0;
      bus.m1_ack            = 1'b0;
      bus.m1_rdata          = '0;

      case (state)
         IDLE: begin
            if (grantValid) nextState = ISSUE;
         end
         ISSUE: begin
            bus.MemBus_Address    = latAddr;
            bus.MemBus_Write_Data = latWe ? latWdata : '0;
            bus.MemWrite          = latWe;
            bus.MemRead           = ~latWe;
            nextState             = (latWe || LAT == 3'd0) ? DONE : WAIT;
         end
         WAIT: begin
            bus.MemBus_Address = latAddr;
            if (waitCnt == 3'd1) nextState = DONE;
         end
         DONE: begin
            if (owner == M_CPU) begin
               bus.m0_ack   = 1'b1;
               bus.m0_rdata = rdCap;
            end else begin
               bus.m1_ack   = 1'b1;
               bus.m1_rdata = rdCap;
            end
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: one instance with READ_LATENCY=1 and a
// registered slave, one with READ_LATENCY=0 and a combinational slave.
module tb_membus_arbiter;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   strobeCnt = 0;
   logic [31:0] rdRegA;

   membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) busA ();
   membus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) busB ();

   membus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA)
   );

   membus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(0)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered slave: data appears the cycle after MemRead.
   always @(posedge clk) begin
      if (busA.MemRead) begin
         rdRegA <= (busA.MemBus_Address == 32'h4000_0008) ? 32'h1234_5678 : ~busA.MemBus_Address;
      end
      if (busA.MemRead || busA.MemWrite) strobeCnt <= strobeCnt + 1;
   end
   assign busA.Device_Read_Data = rdRegA;

   // Combinational slave: returns address + 1.
   assign busB.Device_Read_Data = busB.MemBus_Address + 32'd1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clearInputs();
      busA.m0_req = 0; busA.m0_we = 0; busA.m0_addr = '0; busA.m0_wdata = '0;
      busA.m1_req = 0; busA.m1_we = 0; busA.m1_addr = '0; busA.m1_wdata = '0;
      busB.m0_req = 0; busB.m0_we = 0; busB.m0_addr = '0; busB.m0_wdata = '0;
      busB.m1_req = 0; busB.m1_we = 0; busB.m1_addr = '0; busB.m1_wdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int snap;
      int found;
      rdRegA = '0;
      reset  = 1'b1;
      clearInputs();
      tick();
      tick();

      // Reset state
      check("rst_memread",  32'(busA.MemRead),  32'd0);
      check("rst_memwrite", 32'(busA.MemWrite), 32'd0);
      check("rst_addr",     busA.MemBus_Address, 32'd0);
      check("rst_ack0",     32'(busA.m0_ack),   32'd0);
      check("rst_ack1",     32'(busA.m1_ack),   32'd0);
      reset = 1'b0;
      tick();

      // m0 write 0x10 <- 0xDEADBEEF
      busA.m0_req = 1; busA.m0_we = 1; busA.m0_addr = 32'h10; busA.m0_wdata = 32'hDEAD_BEEF;
      tick();
      check("wr_memwrite", 32'(busA.MemWrite), 32'd1);
      check("wr_memread",  32'(busA.MemRead),  32'd0);
      check("wr_addr",     busA.MemBus_Address, 32'h10);
      check("wr_data",     busA.MemBus_Write_Data, 32'hDEAD_BEEF);
      check("wr_early_ack", 32'(busA.m0_ack), 32'd0);
      tick();
      check("wr_ack0",     32'(busA.m0_ack),   32'd1);
      check("wr_ack1",     32'(busA.m1_ack),   32'd0);
      check("wr_rdata",    busA.m0_rdata,      32'd0);
      check("wr_strobe_off", 32'(busA.MemWrite), 32'd0);
      tick();
      busA.m0_req = 0;
      tick();
      check("wr_no_reissue", 32'(busA.MemWrite | busA.MemRead), 32'd0);

      // m1 read 0x40000008 with one cycle of latency
      busA.m1_req = 1; busA.m1_we = 0; busA.m1_addr = 32'h4000_0008;
      tick();
      check("rd_memread",  32'(busA.MemRead), 32'd1);
      check("rd_addr",     busA.MemBus_Address, 32'h4000_0008);
      check("rd_wdata0",   busA.MemBus_Write_Data, 32'd0);
      tick();
      check("rd_wait_strobe", 32'(busA.MemRead), 32'd0);
      check("rd_wait_addr",   busA.MemBus_Address, 32'h4000_0008);
      check("rd_wait_ack",    32'(busA.m1_ack), 32'd0);
      tick();
      check("rd_ack1",   32'(busA.m1_ack), 32'd1);
      check("rd_ack0",   32'(busA.m0_ack), 32'd0);
      check("rd_rdata",  busA.m1_rdata, 32'h1234_5678);
      check("rd_m0_rdata", busA.m0_rdata, 32'd0);
      tick();
      busA.m1_req = 0;
      tick();

      // Contention straight after reset: strict alternation starting with m0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      busA.m0_req = 1; busA.m0_we = 1; busA.m0_addr = 32'h100; busA.m0_wdata = 32'hA;
      busA.m1_req = 1; busA.m1_we = 1; busA.m1_addr = 32'h200; busA.m1_wdata = 32'hB;
      for (int k = 0; k < 4; k++) begin
         found = 0;
         for (int n = 0; n < 8 && found == 0; n++) begin
            tick();
            if (busA.m0_ack || busA.m1_ack) found = 1;
         end
         check("alt_seen",    32'(found), 32'd1);
         check("alt_onehot",  32'(busA.m0_ack & busA.m1_ack), 32'd0);
         check("alt_order",   32'(busA.m1_ack), 32'(k % 2));
      end
      tick();
      busA.m0_req = 0; busA.m1_req = 0;
      tick();
      tick();

      // READ_LATENCY = 0 instance: read 0x20 returns 0x21 with ack at t+2
      busB.m0_req = 1; busB.m0_we = 0; busB.m0_addr = 32'h20;
      tick();
      check("l0_memread", 32'(busB.MemRead), 32'd1);
      check("l0_early_ack", 32'(busB.m0_ack), 32'd0);
      tick();
      check("l0_ack",   32'(busB.m0_ack), 32'd1);
      check("l0_rdata", busB.m0_rdata, 32'h21);
      check("l0_ack1",  32'(busB.m1_ack), 32'd0);
      tick();
      busB.m0_req = 0;
      tick();

      // Reset while m0 read is in WAIT
      busA.m0_req = 1; busA.m0_we = 0; busA.m0_addr = 32'h30;
      tick();
      tick();
      check("rstmid_wait_addr", busA.MemBus_Address, 32'h30);
      reset = 1'b1;
      tick();
      check("rstmid_ack0",  32'(busA.m0_ack), 32'd0);
      check("rstmid_addr",  busA.MemBus_Address, 32'd0);
      check("rstmid_strobe", 32'(busA.MemRead | busA.MemWrite), 32'd0);
      check("rstmid_rdata", busA.m0_rdata, 32'd0);
      reset = 1'b0;
      busA.m0_req = 0;
      busA.m1_req = 1; busA.m1_we = 1; busA.m1_addr = 32'h44; busA.m1_wdata = 32'h5555_AAAA;
      tick();
      check("rstmid_m1_write", 32'(busA.MemWrite), 32'd1);
      check("rstmid_m1_addr",  busA.MemBus_Address, 32'h44);
      tick();
      check("rstmid_m1_ack",   32'(busA.m1_ack), 32'd1);
      check("rstmid_m0_noack", 32'(busA.m0_ack), 32'd0);
      tick();
      busA.m1_req = 0;
      tick();

      // m0 drops req and changes addr in ISSUE: transaction completes once
      snap = strobeCnt;
      busA.m0_req = 1; busA.m0_we = 0; busA.m0_addr = 32'h50;
      tick();
      check("drop_memread", 32'(busA.MemRead), 32'd1);
      busA.m0_req = 0; busA.m0_addr = 32'h99;
      tick();
      check("drop_addr_latched", busA.MemBus_Address, 32'h50);
      tick();
      check("drop_ack",   32'(busA.m0_ack), 32'd1);
      check("drop_rdata", busA.m0_rdata, ~32'h50);
      tick();
      tick();
      tick();
      check("drop_single_strobe", 32'(strobeCnt - snap), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
